uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated baud divider and input FIFO. It replaces the fixed 8N1 transmitter and baud generator pair. The block accepts words over a valid/ready handshake and buffers them, then serialises each as start, data (LSB first), optional parity and 1 or 2 stop bits. Consecutive frames are sent without gaps. It sits between the design's byte producers and the board TXD pin.

---
 rtl/uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an input FIFO and a built-in baud divider. Words are
//   accepted over a valid/ready handshake and buffered. Each word is then sent
//   as: start bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. Queued frames go out back to back with no idle gap.
//
// Parameters
//   CLK_DIV    clk cycles per bit period (>= 2)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 even, 2 odd (3 behaves as none)
//   STOP_BITS  1 or 2
//   FIFO_DEPTH FIFO entries, power of two, >= 2
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   in_valid    producer offers in_data
//   in_data     word to send
//   in_ready    FIFO has room (fifo_count < FIFO_DEPTH)
//   txd         serial line, idle high, registered
//   busy        a frame is in progress, registered
//   tx_done     one-cycle pulse after each completed frame, registered
//   fifo_count  words currently buffered
module uart_tx_fifo #(
  parameter int CLK_DIV    = 10,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BCNT_W = 4;
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;

  // Transmit FSM and datapath
  state_t               r_state,   w_state_n;
  logic [DATA_BITS-1:0] r_sh,      w_sh_n;
  logic [BCNT_W-1:0]    r_bcnt,    w_bcnt_n;
  logic [DIV_W-1:0]     r_div,     w_div_n;
  logic                 r_par,     w_par_n;
  logic                 r_txd,     w_txd_n;
  logic                 r_tx_done, w_tx_done_n;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_has_word;
  logic                 w_par_calc;
  logic [DATA_BITS-1:0] w_head;

  assign in_ready   = (r_count < (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_count = r_count;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;

  assign w_push     = in_valid && in_ready;
  assign w_has_word = (r_count != '0);
  assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_head     = r_mem[r_rd_ptr];
  // Parity is taken from the word as it leaves the FIFO, before any shifting.
  assign w_par_calc = (PARITY == 2) ? ~^w_head : ^w_head;

  // NOTE: the FIFO array has no reset; only the pointers and count define
  // which entries are valid, so clearing the storage would add logic for nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_bcnt    <= '0;
      r_div     <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_tx_done <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_sh      <= w_sh_n;
      r_bcnt    <= w_bcnt_n;
      r_div     <= w_div_n;
      r_par     <= w_par_n;
      r_txd     <= w_txd_n;
      r_tx_done <= w_tx_done_n;
      r_busy    <= (w_state_n != S_IDLE);
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_n   = r_state;
    w_sh_n      = r_sh;
    w_bcnt_n    = r_bcnt;
    w_div_n     = r_div;
    w_par_n     = r_par;
    w_txd_n     = r_txd;
    w_tx_done_n = 1'b0;
    w_pop       = 1'b0;

    // The baud counter runs in every active state and wraps on each tick.
    if (r_state != S_IDLE) begin
      w_div_n = w_tick ? '0 : r_div + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_has_word) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
        end
      end

      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_txd_n   = r_sh[0];
        end
      end

      S_DATA: begin
        if (w_tick) begin
          w_sh_n = r_sh >> 1;
          if (r_bcnt == BCNT_W'(DATA_BITS - 1)) begin
            w_bcnt_n = '0;
            if (HAS_PAR) begin
              w_state_n = S_PARITY;
              w_txd_n   = r_par;
            end else begin
              w_state_n = S_STOP;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_bcnt_n = r_bcnt + 1'b1;
            w_txd_n  = r_sh[1];
          end
        end
      end

      S_PARITY: begin
        if (w_tick) begin
          w_state_n = S_STOP;
          w_txd_n   = 1'b1;
          w_bcnt_n  = '0;
        end
      end

      S_STOP: begin
        if (w_tick) begin
          if (r_bcnt == BCNT_W'(STOP_BITS - 1)) begin
            w_tx_done_n = 1'b1;
            // A queued word starts its start bit straight after the last stop bit.
            if (w_has_word) begin
              w_pop     = 1'b1;
              w_state_n = S_START;
            end else begin
              w_state_n = S_IDLE;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_bcnt_n = r_bcnt + 1'b1;
          end
        end
      end

      default: w_state_n = S_IDLE;
    endcase

    // Loading a new word is the same from IDLE and from the end of STOP.
    if (w_pop) begin
      w_sh_n   = w_head;
      w_par_n  = w_par_calc;
      w_txd_n  = 1'b0;
      w_bcnt_n = '0;
      w_div_n  = '0;
    end
  end

endmodule
